// File: rtl/tlb_pkg.sv
// Shared types for the 16-entry MIPS TLB: the entry layout, the op codes
// and the Random register update rule.
package tlb_pkg;

    localparam int unsigned N_ENTRY    = 16;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned ENTRY_W    = 71;
    localparam int unsigned VPN2_W     = 19;
    localparam int unsigned PFN_W      = 24;
    localparam int unsigned PA_PFN_W   = 20;
    localparam int unsigned VA_W       = 32;
    localparam int unsigned PAGE_OFS_W = 12;

    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [PFN_W-1:0]  pfn1;
        logic              d1;
        logic              v1;
        logic [PFN_W-1:0]  pfn0;
        logic              d0;
        logic              v0;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'd0,
        OP_TLBR  = 2'd1,
        OP_TLBWI = 2'd2,
        OP_TLBWR = 2'd3
    } tlb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } tlb_state_e;

    // Random counts down and wraps to the top once it reaches Wired or 1, so
    // with Wired=0 it cycles 15..1.
    function automatic logic [IDX_W-1:0] next_random(input logic [IDX_W-1:0] cur,
                                                     input logic [IDX_W-1:0] wired);
        if (cur <= wired || cur <= IDX_W'(1)) begin
            return IDX_W'(N_ENTRY - 1);
        end
        return cur - IDX_W'(1);
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Combinational 16-way TLB match for one virtual page; the lowest valid
// matching index wins.
module tlb_match
    import tlb_pkg::*;
(
    input  tlb_entry_t         entries [N_ENTRY],
    input  logic [VPN2_W:0]    vpage,
    output logic               hit,
    output logic [IDX_W-1:0]   index,
    output logic [PFN_W-1:0]   pfn,
    output logic               dirty
);

    logic odd;
    assign odd = vpage[0];

    // Scan from the top so the lowest matching index is the last one assigned.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        pfn   = '0;
        dirty = 1'b0;
        for (int i = int'(N_ENTRY) - 1; i >= 0; i--) begin
            if (entries[i].vpn2 == vpage[VPN2_W:1] &&
                (odd ? entries[i].v1 : entries[i].v0)) begin
                hit   = 1'b1;
                index = IDX_W'(i);
                pfn   = odd ? entries[i].pfn1 : entries[i].pfn0;
                dirty = odd ? entries[i].d1 : entries[i].d0;
            end
        end
    end

endmodule

// File: rtl/tlb_controller.sv
// MIPS TLB controller: owns the entry array, sequences TLBP/TLBR/TLBWI/TLBWR,
// keeps Random, and arbitrates one lookup path between I and D requesters.
module tlb_controller
    import tlb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid,
    input  logic [1:0]           op_code,
    output logic                 op_ready,
    output logic                 op_done,
    input  logic [IDX_W-1:0]     cp0_index,
    input  logic [IDX_W-1:0]     cp0_wired,
    input  logic [ENTRY_W-1:0]   wr_entry,
    output logic [ENTRY_W-1:0]   rd_entry,
    output logic [IDX_W-1:0]     probe_index,
    output logic                 probe_miss,
    output logic [IDX_W-1:0]     random,
    input  logic                 i_req,
    input  logic [VA_W-1:0]      i_vaddr,
    output logic                 i_grant,
    output logic                 i_rvalid,
    output logic [VA_W-1:0]      i_paddr,
    output logic                 i_miss,
    input  logic                 d_req,
    input  logic [VA_W-1:0]      d_vaddr,
    output logic                 d_grant,
    output logic                 d_rvalid,
    output logic [VA_W-1:0]      d_paddr,
    output logic                 d_miss,
    output logic                 d_dirty
);

    tlb_state_e        state;
    tlb_op_e           op_q;
    logic [IDX_W-1:0]  idx_q;
    tlb_entry_t        entry_q;
    tlb_entry_t        entries [N_ENTRY];
    logic              last_d;

    logic              idle;
    logic [VA_W-1:0]   lookup_va;
    logic              m_hit;
    logic [IDX_W-1:0]  m_index;
    logic [PFN_W-1:0]  m_pfn;
    logic              m_dirty;
    logic [VA_W-1:0]   hit_paddr;
    logic              unused_match;

    logic              probe_hit;
    logic [IDX_W-1:0]  probe_idx;

    assign op_ready = (state == ST_IDLE);

    // Lookups only in IDLE; on a conflict the requester that lost last time wins.
    assign idle      = rst_n && (state == ST_IDLE);
    assign d_grant   = idle && d_req && (!i_req || !last_d);
    assign i_grant   = idle && i_req && (!d_req || last_d);
    assign lookup_va = d_grant ? d_vaddr : i_vaddr;

    tlb_match u_match (
        .entries (entries),
        .vpage   (lookup_va[VA_W-1:PAGE_OFS_W]),
        .hit     (m_hit),
        .index   (m_index),
        .pfn     (m_pfn),
        .dirty   (m_dirty)
    );

    assign hit_paddr    = m_hit ? {m_pfn[PA_PFN_W-1:0], lookup_va[PAGE_OFS_W-1:0]} : '0;
    assign unused_match = ^{m_index, m_pfn[PFN_W-1:PA_PFN_W]};

    // TLBP compares VPN2 only, ignoring the valid bits.
    always_comb begin
        probe_hit = 1'b0;
        probe_idx = '0;
        for (int i = int'(N_ENTRY) - 1; i >= 0; i--) begin
            if (entries[i].vpn2 == entry_q.vpn2) begin
                probe_hit = 1'b1;
                probe_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_q        <= OP_TLBP;
            idx_q       <= '0;
            entry_q     <= '0;
            for (int i = 0; i < int'(N_ENTRY); i++) begin
                entries[i] <= '0;
            end
            random      <= IDX_W'(N_ENTRY - 1);
            rd_entry    <= '0;
            probe_index <= '0;
            probe_miss  <= 1'b0;
            op_done     <= 1'b0;
            last_d      <= 1'b0;
            i_rvalid    <= 1'b0;
            i_paddr     <= '0;
            i_miss      <= 1'b0;
            d_rvalid    <= 1'b0;
            d_paddr     <= '0;
            d_miss      <= 1'b0;
            d_dirty     <= 1'b0;
        end else begin
            random  <= next_random(random, cp0_wired);
            op_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        op_q    <= tlb_op_e'(op_code);
                        idx_q   <= cp0_index;
                        entry_q <= tlb_entry_t'(wr_entry);
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (op_q)
                        OP_TLBP: begin
                            if (probe_hit) begin
                                probe_index <= probe_idx;
                            end
                            probe_miss <= !probe_hit;
                        end
                        OP_TLBR:  rd_entry         <= entries[idx_q];
                        OP_TLBWI: entries[idx_q]   <= entry_q;
                        OP_TLBWR: entries[random]  <= entry_q;
                    endcase
                    op_done <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // One-cycle registered lookup result; held until the next grant.
            i_rvalid <= i_grant;
            d_rvalid <= d_grant;
            if (i_grant) begin
                i_paddr <= hit_paddr;
                i_miss  <= !m_hit;
            end
            if (d_grant) begin
                d_paddr <= hit_paddr;
                d_miss  <= !m_hit;
                d_dirty <= m_hit && m_dirty;
            end
            if (i_grant || d_grant) begin
                last_d <= d_grant;
            end
        end
    end

endmodule

// File: tb/tb_tlb_controller.sv
// Randomized self-checking bench for tlb_controller against a behavioural
// model of the TLB array, Random register and I/D arbiter.
module tb_tlb_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [1:0]  op_code;
    logic        op_ready;
    logic        op_done;
    logic [3:0]  cp0_index;
    logic [3:0]  cp0_wired;
    logic [70:0] wr_entry;
    logic [70:0] rd_entry;
    logic [3:0]  probe_index;
    logic        probe_miss;
    logic [3:0]  random;
    logic        i_req, i_grant, i_rvalid, i_miss;
    logic [31:0] i_vaddr, i_paddr;
    logic        d_req, d_grant, d_rvalid, d_miss, d_dirty;
    logic [31:0] d_vaddr, d_paddr;

    always #5 clk = ~clk;

    tlb_controller dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready), .op_done(op_done),
        .cp0_index(cp0_index), .cp0_wired(cp0_wired),
        .wr_entry(wr_entry), .rd_entry(rd_entry),
        .probe_index(probe_index), .probe_miss(probe_miss), .random(random),
        .i_req(i_req), .i_vaddr(i_vaddr), .i_grant(i_grant), .i_rvalid(i_rvalid),
        .i_paddr(i_paddr), .i_miss(i_miss),
        .d_req(d_req), .d_vaddr(d_vaddr), .d_grant(d_grant), .d_rvalid(d_rvalid),
        .d_paddr(d_paddr), .d_miss(d_miss), .d_dirty(d_dirty)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [70:0] m_tlb [16];
    int          m_rand = 15;
    logic        m_last_d;
    logic [3:0]  m_probe_idx;
    logic        m_probe_miss;
    logic [70:0] m_rd;
    logic        rand_chk_en = 1'b0;
    logic [18:0] vpn_pool [4] = '{19'h00400, 19'h12345, 19'h7FFFF, 19'h00001};

    task automatic check(input string tag, input logic [70:0] got, input logic [70:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Random: counts down each cycle, back to 15 once at Wired or at 1.
    always @(posedge clk) begin
        if (!rst_n || m_rand <= int'(cp0_wired) || m_rand <= 1) m_rand <= 15;
        else m_rand <= m_rand - 1;
    end

    always @(negedge clk) begin
        if (rand_chk_en) check("random", random, 71'(m_rand));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [70:0] rand_entry();
        return {vpn_pool[$urandom_range(0, 3)], 24'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1))};
    endfunction

    function automatic logic [31:0] rand_va();
        if ($urandom_range(0, 7) == 0) return 32'($urandom);
        return {vpn_pool[$urandom_range(0, 3)], 13'($urandom)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_tlb[i] = '0;
        m_last_d     = 1'b0;
        m_probe_idx  = '0;
        m_probe_miss = 1'b0;
        m_rd         = '0;
    endfunction

    // Reference translation: first valid entry whose VPN2 matches, in index order.
    function automatic void xlate(input logic [31:0] va, output logic hit,
                                  output logic [31:0] pa, output logic dy);
        logic [70:0] e;
        logic        odd;
        hit = 1'b0; pa = '0; dy = 1'b0; odd = va[12];
        for (int i = 0; i < 16; i++) begin
            e = m_tlb[i];
            if (!hit && e[70:52] == va[31:13] && (odd ? e[26] : e[0])) begin
                hit = 1'b1;
                pa  = odd ? {e[47:28], va[11:0]} : {e[21:2], va[11:0]};
                dy  = odd ? e[27] : e[1];
            end
        end
    endfunction

    task automatic check_result(input logic was_d, input logic hit,
                                input logic [31:0] pa, input logic dy);
        check("i_rvalid", i_rvalid, !was_d);
        check("d_rvalid", d_rvalid, was_d);
        if (was_d) begin
            check("d_paddr", d_paddr, pa);
            check("d_miss", d_miss, !hit);
            check("d_dirty", d_dirty, dy);
        end else begin
            check("i_paddr", i_paddr, pa);
            check("i_miss", i_miss, !hit);
        end
    endtask

    task automatic lookup(input logic is_d, input logic [31:0] va);
        logic hit; logic [31:0] pa; logic dy;
        i_req   = !is_d;
        d_req   = is_d;
        i_vaddr = is_d ? 32'($urandom) : va;
        d_vaddr = is_d ? va : 32'($urandom);
        #1;
        check("lk_i_grant", i_grant, !is_d);
        check("lk_d_grant", d_grant, is_d);
        xlate(va, hit, pa, dy);
        m_last_d = is_d;
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        check_result(is_d, hit, pa, dy);
    endtask

    task automatic conflict(input int n);
        logic exp_d, prev_d, hit; logic [31:0] pa; logic dy;
        prev_d = 1'b0; hit = 1'b0; pa = '0; dy = 1'b0;
        for (int c = 0; c < n; c++) begin
            i_req = 1'b1; d_req = 1'b1;
            i_vaddr = rand_va(); d_vaddr = rand_va();
            #1;
            exp_d = !m_last_d;
            check("arb_i_grant", i_grant, !exp_d);
            check("arb_d_grant", d_grant, exp_d);
            if (c > 0) check_result(prev_d, hit, pa, dy);
            xlate(exp_d ? d_vaddr : i_vaddr, hit, pa, dy);
            m_last_d = exp_d;
            prev_d   = exp_d;
            @(negedge clk);
        end
        i_req = 1'b0; d_req = 1'b0;
        check_result(prev_d, hit, pa, dy);
    endtask

    task automatic do_op(input logic [1:0] code, input logic [3:0] idx, input logic [70:0] e);
        int   slot;
        logic found;
        check("op_ready_idle", op_ready, 1'b1);
        op_valid = 1'b1; op_code = code; cp0_index = idx; wr_entry = e;
        @(negedge clk);
        op_valid  = 1'b0;
        op_code   = 2'($urandom);
        cp0_index = 4'($urandom);
        wr_entry  = 71'({$urandom, $urandom, $urandom});
        check("op_ready_exec", op_ready, 1'b0);
        check("op_done_exec", op_done, 1'b0);
        slot = m_rand;
        @(negedge clk);
        check("op_done", op_done, 1'b1);
        check("op_ready_done", op_ready, 1'b0);
        case (code)
            2'd0: begin
                found = 1'b0;
                for (int i = 0; i < 16; i++) begin
                    if (!found && m_tlb[i][70:52] == e[70:52]) begin
                        found = 1'b1;
                        m_probe_idx = 4'(i);
                    end
                end
                m_probe_miss = !found;
            end
            2'd1: m_rd = m_tlb[idx];
            2'd2: m_tlb[idx] = e;
            default: m_tlb[slot] = e;
        endcase
        check("probe_index", probe_index, m_probe_idx);
        check("probe_miss", probe_miss, m_probe_miss);
        check("rd_entry", rd_entry, m_rd);
        @(negedge clk);
        check("op_done_pulse", op_done, 1'b0);
        check("op_ready_back", op_ready, 1'b1);
    endtask

    initial begin
        logic [70:0] e;
        logic [31:0] pa;
        logic        hit, dy;
        int          slot;

        rst_n = 1'b0; op_valid = 1'b0; op_code = '0; cp0_index = '0; cp0_wired = '0;
        wr_entry = '0; i_req = 1'b1; d_req = 1'b1; i_vaddr = '0; d_vaddr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_op_ready", op_ready, 1'b1);
        check("rst_op_done", op_done, 1'b0);
        check("rst_rd_entry", rd_entry, '0);
        check("rst_probe_index", probe_index, '0);
        check("rst_probe_miss", probe_miss, 1'b0);
        check("rst_random", random, 71'd15);
        check("rst_grants", {i_grant, d_grant}, '0);
        check("rst_rvalid", {i_rvalid, d_rvalid}, '0);
        check("rst_paddr", {i_paddr, d_paddr}, '0);
        check("rst_miss_dirty", {i_miss, d_miss, d_dirty}, '0);
        i_req = 1'b0; d_req = 1'b0;
        rst_n = 1'b1;
        rand_chk_en = 1'b1;

        // Random with Wired=0 walks 15..1 and wraps.
        for (int k = 0; k < 20; k++) begin
            check("rand_seq_w0", random, 71'((k % 15 == 0) ? 15 : 15 - (k % 15)));
            @(negedge clk);
        end
        cp0_wired = 4'd4;
        for (int t = 0; t < 20 && random != 4'd15; t++) @(negedge clk);
        check("rand_wrap_w4", random, 71'd15);
        for (int k = 0; k < 24; k++) begin
            check("rand_seq_w4", random, 71'(15 - (k % 12)));
            @(negedge clk);
        end
        cp0_wired = 4'd0;

        // First conflict after reset goes to D, then alternates.
        conflict(6);

        e = {19'h00400, 24'h0, 1'b0, 1'b0, 24'h001234, 1'b0, 1'b1};
        do_op(2'd2, 4'd3, e);
        lookup(1'b1, 32'h00800ABC);
        check("dir_even_paddr", d_paddr, 32'h01234ABC);
        check("dir_even_miss", d_miss, 1'b0);
        lookup(1'b1, 32'h00801ABC);
        check("dir_odd_miss", d_miss, 1'b1);
        check("dir_odd_paddr", d_paddr, 32'h0);
        do_op(2'd2, 4'd7, {19'h00400, 24'h0, 1'b0, 1'b0, 24'h000777, 1'b0, 1'b1});
        do_op(2'd0, 4'd0, {19'h00400, 52'h0});
        check("dir_probe_idx", probe_index, 4'd3);
        check("dir_probe_hit", probe_miss, 1'b0);
        do_op(2'd0, 4'd0, {19'h7FFFF, 52'h0});
        check("dir_probe_missbit", probe_miss, 1'b1);
        check("dir_probe_keep", probe_index, 4'd3);

        // TLBWR accepted together with a pending D lookup.
        e = {19'h5A5A5, 24'h0ABCDE, 1'b1, 1'b1, 24'h00F00D, 1'b1, 1'b1};
        op_valid = 1'b1; op_code = 2'd3; wr_entry = e;
        d_req = 1'b1; d_vaddr = {19'h5A5A5, 1'b1, 12'h321};
        #1;
        check("wr_accept_grant", d_grant, 1'b1);
        xlate(d_vaddr, hit, pa, dy);
        m_last_d = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        check_result(1'b1, hit, pa, dy);
        check("wr_exec_grant", {i_grant, d_grant}, '0);
        slot = m_rand;
        @(negedge clk);
        check("wr_done_grant", {i_grant, d_grant}, '0);
        check("wr_done_rvalid", d_rvalid, 1'b0);
        check("wr_op_done", op_done, 1'b1);
        m_tlb[slot] = e;
        @(negedge clk);
        check("wr_idle_grant", d_grant, 1'b1);
        xlate(d_vaddr, hit, pa, dy);
        @(negedge clk);
        d_req = 1'b0;
        check_result(1'b1, hit, pa, dy);
        check("wr_new_paddr", d_paddr, 32'hABCDE321);
        check("wr_new_dirty", d_dirty, 1'b1);
        do_op(2'd1, 4'(slot), '0);
        check("tlbr_equal", rd_entry, e);

        // Reset during EXEC of a TLBWI aborts it.
        op_valid = 1'b1; op_code = 2'd2; cp0_index = 4'd5;
        wr_entry = {19'h2AAAA, 24'h0, 1'b0, 1'b0, 24'h000055, 1'b1, 1'b1};
        @(negedge clk);
        op_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_op_done", op_done, 1'b0);
        check("rstmid_ready", op_ready, 1'b1);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("rstmid_no_done", op_done, 1'b0);
        check("rstmid_rd_entry", rd_entry, '0);
        lookup(1'b1, {19'h2AAAA, 13'h0});
        check("rstmid_lookup_miss", d_miss, 1'b1);

        // Randomized mix of ops, single lookups and conflicts.
        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 5))
                0, 1: do_op(2'($urandom), 4'($urandom), rand_entry());
                2, 3: lookup(1'($urandom_range(0, 1)), rand_va());
                4: conflict($urandom_range(1, 4));
                default: begin
                    cp0_wired = 4'($urandom_range(0, 15));
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
            endcase
        end
        for (int i = 0; i < 16; i++) do_op(2'd1, 4'(i), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
